// File: rtl/bus_exec_pkg.sv
// Shared definitions for the bus execution unit: op codes, sequencer states
// and immediate sign extension.
package bus_exec_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_SHRA = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_NEG  = 4'd9;
  localparam logic [3:0] OP_NOT  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_LDY  = 3'd1;
  localparam state_t S_EX   = 3'd2;
  localparam state_t S_WB   = 3'd3;
  localparam state_t S_WLO  = 3'd4;
  localparam state_t S_WHI  = 3'd5;

  // Replicates bit w-1 upward; callers truncate the 64-bit result to their width.
  function automatic logic [63:0] sext(input logic [63:0] v, input int w);
    logic [63:0] r;
    r = v;
    for (int i = 0; i < 64; i++)
      if (i >= w) r[i] = v[w-1];
    return r;
  endfunction

endpackage

// File: rtl/bus_exec_unit_alu.sv
// Combinational ALU: Z (2*DATA_W) = a op b. High half carries the MUL product
// high word or the DIV remainder; zero for all other ops.
module bus_alu
  import bus_exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]          op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0] z,
  output logic                div0
);

  localparam int SH_W = $clog2(DATA_W);

  logic signed [DATA_W-1:0] sa;
  logic signed [DATA_W-1:0] sb;
  logic [SH_W-1:0]          sh;
  logic [2*DATA_W-1:0]      prod;
  logic [2*DATA_W-1:0]      dbl_r;
  logic [2*DATA_W-1:0]      dbl_l;
  logic [DATA_W-1:0]        quo;
  logic [DATA_W-1:0]        rem;
  logic [DATA_W-1:0]        res;

  assign sa = a;
  assign sb = b;
  assign sh = b[SH_W-1:0];

  // Sign-extending both operands to full width makes the truncated product signed-correct.
  assign prod  = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
  assign dbl_r = {a, a} >> sh;
  assign dbl_l = {a, a} << sh;

  always_comb begin
    quo = '1;
    rem = a;
    if (b != '0) begin
      quo = sa / sb;
      rem = sa % sb;
    end
  end

  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_SHR:  res = a >> sh;
      OP_SHRA: res = sa >>> sh;
      OP_SHL:  res = a << sh;
      OP_ROR:  res = dbl_r[DATA_W-1:0];
      OP_ROL:  res = dbl_l[2*DATA_W-1:DATA_W];
      OP_NEG:  res = -a;
      OP_NOT:  res = ~a;
      default: res = '0;
    endcase
  end

  always_comb begin
    z = {{DATA_W{1'b0}}, res};
    if (op == OP_MUL) z = prod;
    else if (op == OP_DIV) z = {rem, quo};
  end

  assign div0 = (op == OP_DIV) && (b == '0);

endmodule

// File: rtl/bus_exec_unit.sv
// Single-bus execution unit: register file, Y/Z/HI/LO staging and a sequencer
// that walks LDY -> EX -> WB (or WLO -> WHI for MUL/DIV) from one start pulse.
module bus_exec_unit
  import bus_exec_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int IMM_W    = 19,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic [REG_AW-1:0] rc,
  input  logic              use_imm,
  input  logic [IMM_W-1:0]  imm,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              div0,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  state_t              state;
  logic [DATA_W-1:0]   y;
  logic [2*DATA_W-1:0] z;
  logic                z_div0;
  logic [DATA_W-1:0]   bus;
  logic [2*DATA_W-1:0] alu_z;
  logic                alu_div0;

  logic [3:0]          op_q;
  logic [REG_AW-1:0]   ra_q;
  logic [REG_AW-1:0]   rb_q;
  logic [REG_AW-1:0]   rc_q;
  logic                use_imm_q;
  logic [IMM_W-1:0]    imm_q;

  // Instruction fields are captured at acceptance so the caller may change them while busy.
  always_ff @(posedge clock) begin
    if (state == S_IDLE && start) begin
      op_q      <= op;
      ra_q      <= ra;
      rb_q      <= rb;
      rc_q      <= rc;
      use_imm_q <= use_imm;
      imm_q     <= imm;
    end
  end

  always_comb begin
    bus = '0;
    case (state)
      S_LDY: bus = regs[ra_q];
      S_EX:  bus = use_imm_q ? DATA_W'(sext(64'(imm_q), IMM_W)) : regs[rb_q];
      S_WB:  bus = z[DATA_W-1:0];
      default: bus = '0;
    endcase
  end

  bus_alu #(.DATA_W(DATA_W)) u_alu (
    .op   (op_q),
    .a    (y),
    .b    (bus),
    .z    (alu_z),
    .div0 (alu_div0)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state  <= S_IDLE;
      done   <= 1'b0;
      div0   <= 1'b0;
      y      <= '0;
      z      <= '0;
      z_div0 <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_en) regs[wr_addr] <= wr_data;
          if (start) state <= S_LDY;
        end
        S_LDY: begin
          y     <= bus;
          state <= S_EX;
        end
        S_EX: begin
          z      <= alu_z;
          z_div0 <= alu_div0;
          state  <= (op_q == OP_MUL || op_q == OP_DIV) ? S_WLO : S_WB;
        end
        S_WB: begin
          regs[rc_q] <= bus;
          done       <= 1'b1;
          div0       <= z_div0;
          state      <= S_IDLE;
        end
        S_WLO: begin
          lo    <= z[DATA_W-1:0];
          state <= S_WHI;
        end
        S_WHI: begin
          hi    <= z[2*DATA_W-1:DATA_W];
          done  <= 1'b1;
          div0  <= z_div0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign rd_data = regs[rd_addr];

endmodule

// File: tb/tb_bus_exec_unit.sv
// Directed bench for bus_exec_unit: vector table of single ops plus hand-written
// sequences for same-cycle write, busy-time requests, back-to-back and abort.
module tb_bus_exec_unit;

  localparam int DATA_W = 32;
  localparam int NUM_REGS = 16;
  localparam int IMM_W = 19;
  localparam int REG_AW = 4;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, SHR = 4'd4,
                         SHRA = 4'd5, SHL = 4'd6, ROR = 4'd7, ROL = 4'd8, NEG = 4'd9,
                         NOT_ = 4'd10, MUL = 4'd11, DIV = 4'd12, NOP = 4'd13;

  logic              clock = 1'b0;
  logic              clear = 1'b1;
  logic              start = 1'b0;
  logic [3:0]        op = '0;
  logic [REG_AW-1:0] ra = '0, rb = '0, rc = '0;
  logic              use_imm = 1'b0;
  logic [IMM_W-1:0]  imm = '0;
  logic              wr_en = 1'b0;
  logic [REG_AW-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [REG_AW-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              busy, done, div0;
  logic [DATA_W-1:0] hi, lo;

  int total = 0;
  int bad = 0;

  bus_exec_unit #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IMM_W(IMM_W)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .use_imm(use_imm), .imm(imm), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .div0(div0),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  ra, rb, rc;
    logic        ui;
    logic [18:0] imm;
    logic [31:0] a, b;
    logic [31:0] res, hi, lo;
    logic        dv0;
    logic        md;
  } vec_t;

  vec_t vt [20];

  function automatic vec_t mk(logic [3:0] o, logic [3:0] xa, logic [3:0] xb, logic [3:0] xc,
                              logic u, logic [18:0] im, logic [31:0] a, logic [31:0] b,
                              logic [31:0] res, logic [31:0] h, logic [31:0] l, logic d, logic m);
    vec_t v;
    v.op = o; v.ra = xa; v.rb = xb; v.rc = xc; v.ui = u; v.imm = im;
    v.a = a; v.b = b; v.res = res; v.hi = h; v.lo = l; v.dv0 = d; v.md = m;
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic rdchk(input string nm, input logic [3:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    chk(nm, 64'(rd_data), 64'(exp));
  endtask

  task automatic wreg(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic issue(input logic [3:0] o, input logic [3:0] xa, input logic [3:0] xb,
                       input logic [3:0] xc, input logic u, input logic [18:0] im);
    op = o; ra = xa; rb = xb; rc = xc; use_imm = u; imm = im;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called in cycle 1 after acceptance; returns the cycle number where done was seen.
  task automatic wait_done(output int lat, output int busy_low);
    lat = 1;
    busy_low = 0;
    while (!done && lat < 20) begin
      if (!busy) busy_low++;
      step();
      lat++;
    end
  endtask

  initial begin
    int lat, bl, cnt;
    vt[0]  = mk(ADD,  1, 2, 3, 0, 0, 32'd5, 32'd7, 32'd12, 0, 0, 0, 0);
    vt[1]  = mk(ADD,  1, 2, 3, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 0, 0);
    vt[2]  = mk(SUB,  1, 2, 3, 0, 0, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 0, 0, 0);
    vt[3]  = mk(AND_, 1, 2, 3, 0, 0, 32'hF0F0, 32'hFF00, 32'hF000, 0, 0, 0, 0);
    vt[4]  = mk(OR_,  1, 2, 3, 0, 0, 32'hF0F0, 32'h0F0F, 32'hFFFF, 0, 0, 0, 0);
    vt[5]  = mk(SHR,  4, 2, 5, 1, 19'd4, 32'h8000_0000, 32'hDEAD, 32'h0800_0000, 0, 0, 0, 0);
    vt[6]  = mk(SHRA, 4, 2, 5, 1, 19'd4, 32'h8000_0000, 32'hDEAD, 32'hF800_0000, 0, 0, 0, 0);
    vt[7]  = mk(SHL,  1, 2, 3, 1, 19'd33, 32'd1, 32'hDEAD, 32'd2, 0, 0, 0, 0);
    vt[8]  = mk(ROR,  1, 2, 3, 1, 19'd1, 32'd1, 32'hDEAD, 32'h8000_0000, 0, 0, 0, 0);
    vt[9]  = mk(ROL,  4, 2, 5, 1, 19'd1, 32'h8000_0000, 32'hDEAD, 32'h0000_0001, 0, 0, 0, 0);
    vt[10] = mk(NEG,  1, 2, 3, 0, 0, 32'd5, 32'hDEAD, 32'hFFFF_FFFB, 0, 0, 0, 0);
    vt[11] = mk(NOT_, 1, 2, 3, 0, 0, 32'h0F0F_0F0F, 32'hDEAD, 32'hF0F0_F0F0, 0, 0, 0, 0);
    vt[12] = mk(NOP,  1, 2, 3, 0, 0, 32'd5, 32'd7, 32'd0, 0, 0, 0, 0);
    vt[13] = mk(ADD,  1, 2, 3, 1, 19'h7FFFF, 32'd5, 32'hDEAD, 32'd4, 0, 0, 0, 0);
    vt[14] = mk(MUL,  1, 2, 3, 0, 0, 32'hFFFF_FFFD, 32'd7, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 1);
    vt[15] = mk(MUL,  1, 2, 3, 0, 0, 32'h0001_0000, 32'h0001_0000, 0, 32'd1, 32'd0, 0, 1);
    vt[16] = mk(DIV,  1, 2, 3, 0, 0, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1);
    vt[17] = mk(DIV,  1, 2, 3, 0, 0, 32'd9, 32'd0, 0, 32'd9, 32'hFFFF_FFFF, 1, 1);
    vt[18] = mk(ADD,  1, 2, 3, 0, 0, 32'd1, 32'd1, 32'd2, 0, 0, 0, 0);
    vt[19] = mk(DIV,  1, 2, 3, 0, 0, 32'd7, 32'hFFFF_FFFE, 0, 32'd1, 32'hFFFF_FFFD, 0, 1);

    // Reset state
    step(); step();
    clear = 1'b0;
    step();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_div0", 64'(div0), 0);
    chk("rst_hi", 64'(hi), 0);
    chk("rst_lo", 64'(lo), 0);
    for (int r = 0; r < NUM_REGS; r++) rdchk($sformatf("rst_r%0d", r), 4'(r), 32'd0);

    // Table-driven single operations
    for (int i = 0; i < 20; i++) begin
      wreg(vt[i].ra, vt[i].a);
      wreg(vt[i].rb, vt[i].b);
      wreg(vt[i].rc, 32'hA5A5_A5A5);
      issue(vt[i].op, vt[i].ra, vt[i].rb, vt[i].rc, vt[i].ui, vt[i].imm);
      wait_done(lat, bl);
      chk($sformatf("v%0d_latency", i), 64'(lat), vt[i].md ? 64'd5 : 64'd4);
      chk($sformatf("v%0d_busy_during", i), 64'(bl), 0);
      chk($sformatf("v%0d_busy_at_done", i), 64'(busy), 0);
      chk($sformatf("v%0d_div0", i), 64'(div0), 64'(vt[i].dv0));
      if (vt[i].md) begin
        chk($sformatf("v%0d_hi", i), 64'(hi), 64'(vt[i].hi));
        chk($sformatf("v%0d_lo", i), 64'(lo), 64'(vt[i].lo));
        rdchk($sformatf("v%0d_rc_kept", i), vt[i].rc, 32'hA5A5_A5A5);
      end else begin
        rdchk($sformatf("v%0d_rc", i), vt[i].rc, vt[i].res);
      end
      step();
      chk($sformatf("v%0d_done_pulse", i), 64'(done), 0);
    end

    // start and wr_en to ra in the same IDLE cycle
    wreg(1, 32'd5);
    wreg(2, 32'd8);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'd42;
    issue(ADD, 1, 2, 3, 0, 0);
    wr_en = 1'b0;
    wait_done(lat, bl);
    chk("same_cycle_wr_latency", 64'(lat), 4);
    rdchk("same_cycle_wr_r3", 4'd3, 32'd50);

    // start and wr_en during busy are ignored
    wreg(1, 32'd5);
    wreg(2, 32'd7);
    wreg(6, 32'h1111);
    issue(ADD, 1, 2, 3, 0, 0);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'd100;
    op = SUB; rc = 4'd6; start = 1'b1;
    step(); step();
    wr_en = 1'b0; start = 1'b0;
    wait_done(lat, bl);
    chk("busy_ign_done", 64'(done), 1);
    rdchk("busy_ign_r3", 4'd3, 32'd12);
    rdchk("busy_ign_r1", 4'd1, 32'd5);
    rdchk("busy_ign_r6", 4'd6, 32'h1111);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (busy || done) cnt++;
    end
    chk("busy_ign_no_second_op", 64'(cnt), 0);

    // Back-to-back: start in the done cycle is accepted
    issue(ADD, 1, 2, 3, 0, 0);
    wait_done(lat, bl);
    chk("b2b_first_done", 64'(done), 1);
    op = SUB; ra = 4'd1; rb = 4'd2; rc = 4'd4; use_imm = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 1);
    wait_done(lat, bl);
    chk("b2b_latency", 64'(lat), 4);
    rdchk("b2b_r4", 4'd4, 32'hFFFF_FFFE);

    // clear in cycle 2 of an op aborts it
    wreg(3, 32'h7777);
    issue(ADD, 1, 2, 3, 0, 0);
    step();
    clear = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_done", 64'(done), 0);
    chk("abort_hi", 64'(hi), 0);
    chk("abort_lo", 64'(lo), 0);
    rdchk("abort_r1", 4'd1, 32'd0);
    rdchk("abort_r3", 4'd3, 32'd0);
    step();
    clear = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done || busy) cnt++;
    end
    chk("abort_no_done", 64'(cnt), 0);
    rdchk("abort_r3_after", 4'd3, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_exec_unit.md
# bus_exec_unit

Parametrised successor to the single-bus CPU datapath: a register file of NUM_REGS × DATA_W registers, Y/Z/HI/LO staging registers, a shared internal bus and an ALU. An internal sequencer drives these through the multi-cycle register-transfer sequence (Ry←Ra, Z←Ry op B, Rc←Zlo, with extra HI/LO steps for MUL/DIV), so callers issue one `start` instead of hand-driven per-register in/out strobes. It sits between the control unit and the register file and memory side of the CPU.

## Interface
- DATA_W, 32, data and bus width (≥8, even)
- NUM_REGS, 16, general registers (power of 2); REG_AW = log2(NUM_REGS)
- IMM_W, 19, immediate field width, sign-extended to DATA_W
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous, active-high reset
- start  in  1  issue request; sampled only in IDLE
- op  in  4  operation code (see Operation)
- ra, rb, rc  in  REG_AW each  source A, source B, destination
- use_imm  in  1  B operand = sign-extended imm instead of R[rb]
- imm  in  IMM_W  immediate
- wr_en  in  1  host register write; honoured only in IDLE
- wr_addr  in  REG_AW  host write index
- wr_data  in  DATA_W  host write data
- rd_addr  in  REG_AW  host read index
- rd_data  out  DATA_W  R[rd_addr], combinational
- busy  out  1  sequencer not in IDLE
- done  out  1  one-cycle completion pulse
- div0  out  1  valid with done; last DIV had a zero divisor
- hi, lo  out  DATA_W  HI/LO register contents

## Operation
- Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG, 10 NOT, 11 MUL, 12 DIV; 13–15 are NOP. A NOP runs the full ALU sequence, writes 0 to Rc, and asserts done.
- States: IDLE → LDY → EX → WB → IDLE. For MUL/DIV the path is IDLE → LDY → EX → WLO → WHI → IDLE.
- LDY: bus = R[ra]; Y ← bus.
- EX: bus = use_imm ? sext(imm) : R[rb]; Z (2·DATA_W) ← alu(Y, bus).
- WB: bus = Z[DATA_W-1:0]; R[rc] ← bus.
- WLO: LO ← Z low half. WHI: HI ← Z high half. Rc is not written on this path.
- Arithmetic:
  - ADD/SUB wrap modulo 2^DATA_W.
  - Shift and rotate amounts = B[log2(DATA_W)-1:0].
  - SHRA is arithmetic.
  - NEG and NOT operate on Y and ignore B.
  - MUL is signed, with the full 2·DATA_W product. Zhi = product high half.
  - DIV is signed, truncating toward zero. Zlo = quotient, Zhi = remainder; the remainder takes the sign of the dividend.
  - DIV by 0: quotient = all ones, remainder = dividend, div0 = 1.
  - div0 is updated on every completed op; it is 0 for every op other than DIV-by-0.
- `start` while busy is ignored.
- `wr_en` while busy is ignored; the register file is owned by the sequencer while busy.
- `start` and `wr_en` in the same IDLE cycle: the write lands on that edge. If wr_addr == ra, LDY reads the new value.
- rd_addr == rc during WB: rd_data shows the old value until the WB edge.

## Timing
- Reset (clear = 1, asynchronous):
  - All R[i], Y, Z, HI and LO are 0.
  - State is IDLE.
  - busy, done and div0 are 0; rd_data is 0.
- Edge numbering: edge 0 is the edge that samples `start`.
- busy is high from after edge 0 until the edge that returns to IDLE.
- ALU ops: Rc is written at edge 3. done is high for the cycle after edge 3; busy is low in that same cycle.
- MUL/DIV: LO is written at edge 3 and HI at edge 4. done is high for the cycle after edge 4.
- Back-to-back: `start` may be asserted in the cycle in which done is high. That cycle is IDLE, so the request is accepted.
- clear mid-operation aborts immediately. No partial write survives, and done is not asserted.

## Structure
- Shared package `bus_exec_pkg`: op-code localparams, state enum, and a `sext` function.
- Sub-module `bus_alu` holds the combinational ALU, parametrised by DATA_W. It is instantiated once.
- The register file, bus mux and sequencer live in the top level.

## Test plan
- Reset then idle: rd_data = 0 for every rd_addr; busy = 0, done = 0, hi = 0, lo = 0.
- R1 = 5, R2 = 7, ADD ra=1 rb=2 rc=3 → done exactly 4 cycles after the start cycle; R3 = 12; busy asserted for cycles 1–3.
- R4 = 0x8000_0000, SHRA use_imm imm = 4 rc=5 → R5 = 0xF800_0000. Same setup with ROL imm = 1 → R5 = 0x0000_0001.
- MUL R1 = −3 (0xFFFF_FFFD), R2 = 7 → lo = 0xFFFF_FFEB, hi = 0xFFFF_FFFF, done at cycle 5. DIV R1 = −7, R2 = 2 → lo = −3, hi = −1.
- DIV with R2 = 0, R1 = 9 → lo = 0xFFFF_FFFF, hi = 9, div0 = 1 with done. A following ADD clears div0.
- Corner cases:
  - start + wr_en(ra, 42) in the same cycle → result uses 42.
  - start or wr_en during busy → ignored.
  - clear at cycle 2 of an op → all registers 0 and no done.
